// File: rtl/usb_ft1248_responder.sv
// Device-side FT1248 responder: synchronises the master's strobes, decodes the command byte,
// ACKs/NAKs on MISO and moves bytes through RX/TX FIFOs. Power-save: USB_FT1248_RESPONDER_PWRSAV_EN.
`timescale 1ns/1ps

module usb_ft1248_responder #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CMD_WRITE  = 8'h00,
  parameter logic [7:0] CMD_READ   = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_clk,
  input  logic       usb_cs,
  output logic       usb_miso,
  input  logic [7:0] usb_miosi_in,
  output logic [7:0] usb_miosi_out,
  output logic       usb_miosi_oe,
  output logic       usb_pwrsav,
  input  logic       suspend,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_TURN, S_WRITE, S_READ, S_ABORT
  } state_e;

  state_e     state_q;
  logic       uclk_s1_q, uclk_s2_q, uclk_prev_q;
  logic       cs_s1_q, cs_s2_q;
  logic [7:0] miosi_s1_q, miosi_s2_q;
  logic       is_read_q, miso_q, oe_q;
  logic [7:0] out_q;
  logic       rise, fall, cmd_ok, susp_block;

  // RX FIFO (master -> device)
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic        rx_full, rx_empty, rx_push, rx_push_ok, rx_pop_ok, rx_valid_q;

  // TX FIFO (device -> master)
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic        tx_full, tx_empty, tx_full_d, tx_pop, tx_push_ok, tx_pop_ok, tx_ready_q;
  logic [7:0]  tx_head;

  // Two-flop synchronisers; uclk_prev_q gives the third stage used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uclk_s1_q   <= 1'b0;
      uclk_s2_q   <= 1'b0;
      uclk_prev_q <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      miosi_s1_q  <= 8'h00;
      miosi_s2_q  <= 8'h00;
    end else begin
      uclk_s1_q   <= usb_clk;
      uclk_s2_q   <= uclk_s1_q;
      uclk_prev_q <= uclk_s2_q;
      cs_s1_q     <= usb_cs;
      cs_s2_q     <= cs_s1_q;
      miosi_s1_q  <= usb_miosi_in;
      miosi_s2_q  <= miosi_s1_q;
    end
  end

  assign rise = uclk_s2_q & ~uclk_prev_q;
  assign fall = ~uclk_s2_q & uclk_prev_q;

`ifdef USB_FT1248_RESPONDER_PWRSAV_EN
  logic pwrsav_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwrsav_q <= 1'b1;
    else        pwrsav_q <= ~suspend;
  end
  assign usb_pwrsav = pwrsav_q;
  assign susp_block = suspend;
`else
  logic unused_suspend;
  assign unused_suspend = suspend;
  assign usb_pwrsav     = 1'b1;
  assign susp_block     = 1'b0;
`endif

  assign cmd_ok = ((miosi_s2_q == CMD_WRITE) || (miosi_s2_q == CMD_READ)) && !susp_block;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      is_read_q <= 1'b0;
      miso_q    <= 1'b1;
      oe_q      <= 1'b0;
      out_q     <= 8'h00;
    end else if (cs_s2_q) begin
      // Slave-select released: back off the bus, any partial byte is simply lost.
      state_q <= S_IDLE;
      miso_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_CMD;
        end
        S_CMD: begin
          if (rise) begin
            is_read_q <= (miosi_s2_q == CMD_READ);
            state_q   <= cmd_ok ? S_TURN : S_ABORT;
          end
        end
        S_TURN: begin
          if (fall) begin
            if (!is_read_q) begin
              if (!rx_full) begin
                miso_q  <= 1'b0;
                state_q <= S_WRITE;
              end else begin
                miso_q  <= 1'b1;
                state_q <= S_ABORT;
              end
            end else if (!tx_empty) begin
              oe_q    <= 1'b1;
              out_q   <= tx_head;
              miso_q  <= 1'b0;
              state_q <= S_READ;
            end else begin
              miso_q  <= 1'b1;
              state_q <= S_ABORT;
            end
          end
        end
        S_WRITE: begin
          // Once NAKed the write stays NAKed even if the consumer frees space.
          if (fall && !miso_q) miso_q <= rx_full;
        end
        S_READ: begin
          if (fall) begin
            if (!tx_empty) begin
              out_q  <= tx_head;
              miso_q <= 1'b0;
            end else begin
              miso_q <= 1'b1;
            end
          end
        end
        S_ABORT: begin
          miso_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign usb_miso      = miso_q;
  assign usb_miosi_oe  = oe_q;
  assign usb_miosi_out = out_q;

  // Transfers happen only on a rise that follows an ACKed fall.
  assign rx_push = (state_q == S_WRITE) && rise && !miso_q && !cs_s2_q;
  assign tx_pop  = (state_q == S_READ)  && rise && !miso_q && !cs_s2_q;

  // RX FIFO: pointers carry an extra wrap bit to tell full from empty.
  assign rx_full    = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_empty   = (rx_wr_q == rx_rd_q);
  assign rx_push_ok = rx_push && !rx_full;
  assign rx_pop_ok  = rx_valid_q && rx_ready && !rx_empty;

  always_comb begin
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    if (rx_push_ok) rx_wr_d = rx_wr_q + {{AW{1'b0}}, 1'b1};
    if (rx_pop_ok)  rx_rd_d = rx_rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_valid_q <= (rx_wr_d != rx_rd_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem_q[rx_wr_q[AW-1:0]] <= miosi_s2_q;
  end

  assign rx_data  = rx_mem_q[rx_rd_q[AW-1:0]];
  assign rx_valid = rx_valid_q;

  // TX FIFO: same structure, pushed by the local producer, popped by master reads.
  assign tx_full    = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_empty   = (tx_wr_q == tx_rd_q);
  assign tx_push_ok = tx_valid && tx_ready_q && !tx_full;
  assign tx_pop_ok  = tx_pop && !tx_empty;
  assign tx_head    = tx_mem_q[tx_rd_q[AW-1:0]];

  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    if (tx_push_ok) tx_wr_d = tx_wr_q + {{AW{1'b0}}, 1'b1};
    if (tx_pop_ok)  tx_rd_d = tx_rd_q + {{AW{1'b0}}, 1'b1};
  end

  assign tx_full_d = (tx_wr_d[AW] != tx_rd_d[AW]) && (tx_wr_d[AW-1:0] == tx_rd_d[AW-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_ready_q <= !tx_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data;
  end

  assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_usb_ft1248_responder.sv
// Bench for usb_ft1248_responder: an FT1248 master model drives transactions, and scoreboards
// check the bus response at each master sample point and every byte leaving the RX FIFO.
`timescale 1ns/1ps

module tb_usb_ft1248_responder;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       usb_clk = 1'b0;
  logic       usb_cs = 1'b1;
  logic       usb_miso;
  logic [7:0] usb_miosi_in = 8'h00;
  logic [7:0] usb_miosi_out;
  logic       usb_miosi_oe;
  logic       usb_pwrsav;
  logic       suspend = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Expected bus state at a master sample point: {oe, miso, data, check_data}.
  typedef struct packed {
    logic       oe;
    logic       miso;
    logic [7:0] data;
    logic       chk_data;
  } bus_exp_t;

  bus_exp_t   exp_bus_q[$];
  logic [7:0] exp_q[$];
  event       bus_sample_ev;

  usb_ft1248_responder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .usb_clk(usb_clk), .usb_cs(usb_cs), .usb_miso(usb_miso),
    .usb_miosi_in(usb_miosi_in), .usb_miosi_out(usb_miosi_out), .usb_miosi_oe(usb_miosi_oe),
    .usb_pwrsav(usb_pwrsav), .suspend(suspend), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic expect_bus(input logic oe, input logic miso, input logic [7:0] d,
                            input logic chk);
    bus_exp_t e;
    e.oe = oe; e.miso = miso; e.data = d; e.chk_data = chk;
    exp_bus_q.push_back(e);
  endtask

  task automatic cs_start();
    usb_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    usb_cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    usb_miosi_in = c;
    wait_clk(HALF);
    usb_clk = 1'b1;
    wait_clk(HALF);
    usb_clk = 1'b0;
  endtask

  task automatic clock_byte(input logic [7:0] d);
    usb_miosi_in = d;
    wait_clk(HALF);
    -> bus_sample_ev;
    usb_clk = 1'b1;
    wait_clk(HALF);
    usb_clk = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int t;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 50) begin
      wait_clk(1);
      t++;
    end
    if (!tx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL tx_push_timeout: tx_ready=%0b required 1", tx_ready);
    end
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain_rx();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      wait_clk(1);
      t++;
    end
    check("rx_drain_left", exp_q.size(), 0);
  endtask

  // Monitor: bus response at each master sample point
  initial begin
    bus_exp_t e;
    forever begin
      @(bus_sample_ev);
      n_checks++;
      if (exp_bus_q.size() == 0) begin
        n_errors++;
        $display("FAIL bus_unexpected: miso=%0b oe=%0b with no expectation", usb_miso, usb_miosi_oe);
      end else begin
        e = exp_bus_q.pop_front();
        if (usb_miso !== e.miso || usb_miosi_oe !== e.oe ||
            (e.chk_data && usb_miosi_out !== e.data)) begin
          n_errors++;
          $display("FAIL bus_sample: miso=%0b oe=%0b out=%02h required miso=%0b oe=%0b out=%02h",
                   usb_miso, usb_miosi_oe, usb_miosi_out, e.miso, e.oe, e.data);
        end
      end
    end
  end

  // Monitor: bytes leaving the RX FIFO
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rx_unexpected: rx_data=%02h with no expectation", rx_data);
      end else begin
        logic [7:0] x;
        x = exp_q.pop_front();
        if (rx_data !== x) begin
          n_errors++;
          $display("FAIL rx_data: got %02h expected %02h", rx_data, x);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] wr3 [3];
    logic [7:0] wr6 [6];
    wr3 = '{8'hA5, 8'h5A, 8'hFF};
    wr6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    wait_clk(3);
    check("reset_miso", usb_miso, 1);
    check("reset_oe", usb_miosi_oe, 0);
    check("reset_out", usb_miosi_out, 8'h00);
    check("reset_pwrsav", usb_pwrsav, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_ready", tx_ready, 1);
    reset = 1'b1;
    wait_clk(4);

    // Write, 3 bytes, consumer always ready
    rx_ready = 1'b1;
    cs_start();
    send_cmd(8'h00);
    for (int i = 0; i < 3; i++) begin
      expect_bus(1'b0, 1'b0, 8'h00, 1'b0);
      exp_q.push_back(wr3[i]);
      clock_byte(wr3[i]);
    end
    cs_end();
    drain_rx();
    check("write_idle_miso", usb_miso, 1);

    // Read, 2 bytes then a NAKed third
    push_tx(8'h12);
    push_tx(8'h34);
    cs_start();
    send_cmd(8'h40);
    expect_bus(1'b1, 1'b0, 8'h12, 1'b1);
    clock_byte(8'h00);
    expect_bus(1'b1, 1'b0, 8'h34, 1'b1);
    clock_byte(8'h00);
    expect_bus(1'b1, 1'b1, 8'h34, 1'b1);
    clock_byte(8'h00);
    cs_end();
    check("read_oe_released", usb_miosi_oe, 0);
    check("read_tx_ready", tx_ready, 1);

    // RX full: depth 4, consumer stalled, 6 bytes offered
    rx_ready = 1'b0;
    cs_start();
    send_cmd(8'h00);
    for (int i = 0; i < 6; i++) begin
      expect_bus(1'b0, (i >= 4) ? 1'b1 : 1'b0, 8'h00, 1'b0);
      if (i < 4) exp_q.push_back(wr6[i]);
      clock_byte(wr6[i]);
    end
    cs_end();
    check("rxfull_rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    drain_rx();
    wait_clk(2);
    check("rxfull_drained", rx_valid, 0);

    // Bad command
    cs_start();
    send_cmd(8'h7E);
    expect_bus(1'b0, 1'b1, 8'h00, 1'b0);
    clock_byte(8'h99);
    expect_bus(1'b0, 1'b1, 8'h00, 1'b0);
    clock_byte(8'h98);
    cs_end();
    check("badcmd_rx_valid", rx_valid, 0);
    check("badcmd_tx_ready", tx_ready, 1);

    // Abort mid-read: fill TX, read one byte, release cs
    push_tx(8'hA1);
    push_tx(8'hA2);
    push_tx(8'hA3);
    push_tx(8'hA4);
    check("tx_full_ready", tx_ready, 0);
    cs_start();
    send_cmd(8'h40);
    expect_bus(1'b1, 1'b0, 8'hA1, 1'b1);
    clock_byte(8'h00);
    wait_clk(HALF);
    check("abort_oe_before", usb_miosi_oe, 1);
    check("abort_out_next", usb_miosi_out, 8'hA2);
    usb_cs = 1'b1;
    wait_clk(3);
    check("abort_oe_released", usb_miosi_oe, 0);
    check("abort_miso", usb_miso, 1);
    check("abort_tx_ready", tx_ready, 1);
    wait_clk(HALF);
    cs_start();
    send_cmd(8'h40);
    expect_bus(1'b1, 1'b0, 8'hA2, 1'b1);
    clock_byte(8'h00);
    expect_bus(1'b1, 1'b0, 8'hA3, 1'b1);
    clock_byte(8'h00);
    expect_bus(1'b1, 1'b0, 8'hA4, 1'b1);
    clock_byte(8'h00);
    expect_bus(1'b1, 1'b1, 8'hA4, 1'b1);
    clock_byte(8'h00);
    cs_end();

    // Reset mid-write
    rx_ready = 1'b0;
    cs_start();
    send_cmd(8'h00);
    expect_bus(1'b0, 1'b0, 8'h00, 1'b0);
    clock_byte(8'h77);
    wait_clk(HALF);
    check("rst_pre_miso", usb_miso, 0);
    check("rst_pre_rx_valid", rx_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    check("rst_miso", usb_miso, 1);
    check("rst_oe", usb_miosi_oe, 0);
    check("rst_out", usb_miosi_out, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_pwrsav", usb_pwrsav, 1);
    usb_cs = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
    check("rst_rx_empty_after", rx_valid, 0);
    rx_ready = 1'b1;
    wait_clk(4);

    check("bus_exp_left", exp_bus_q.size(), 0);
    check("rx_exp_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
